// File: rtl/i2c_poll_pkg.sv
// Shared types and default constants for the i2c_poll sensor poller.
package i2c_poll_pkg;

  localparam int unsigned PERIOD_CYC_DEF  = 1000000;
  localparam int unsigned AVG_LOG2_DEF    = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;
  localparam int unsigned SAMPLE_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCUM,
    ST_OUTPUT
  } poll_state_e;

endpackage

// File: rtl/i2c_poll_tick.sv
// Poll-period tick generator: counts 0..PERIOD_CYC-1 while enabled, pulses tick on wrap.
module poll_tick
  import i2c_poll_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = en && (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_poll.sv
// Periodic I2C read poller with 2^AVG_LOG2 sample averaging.
// Optional build macro POLL_TIMEOUT_EN adds a REQ wait timeout.
module i2c_poll
  import i2c_poll_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int unsigned AVG_LOG2    = AVG_LOG2_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        start,
  input  logic        done,
  input  logic [7:0]  msb,
  input  logic [7:0]  lsb,
  output logic [15:0] sample,
  output logic        sample_vld,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  localparam int unsigned      ACC_W    = SAMPLE_W + AVG_LOG2;
  localparam int unsigned      CNT_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** AVG_LOG2);

  if (PERIOD_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("i2c_poll: PERIOD_CYC and TIMEOUT_CYC must be nonzero");
  end

  poll_state_e         r_state;
  poll_state_e         w_next;
  logic [15:0]         r_cap;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_sample;
  logic                r_overrun;
  logic                w_tick;
  logic                w_to_hit;
  logic [ACC_W-1:0]    w_sum;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last;

  poll_tick #(
    .PERIOD_CYC(PERIOD_CYC)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(w_tick)
  );

  assign w_sum     = r_acc + ACC_W'(r_cap);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == CNT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    start      = 1'b0;
    busy       = 1'b1;
    sample_vld = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_tick) begin
          w_next = ST_REQ;
        end
      end
      ST_REQ: begin
        start = 1'b1;
        if (done) begin
          w_next = ST_ACCUM;
        end else if (w_to_hit) begin
          w_next = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        w_next = w_last ? ST_OUTPUT : ST_IDLE;
      end
      ST_OUTPUT: begin
        sample_vld = 1'b1;
        w_next     = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // sample is registered on the ACCUM->OUTPUT edge so it is already valid
  // in the single OUTPUT cycle that carries sample_vld (done + 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sample  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_REQ: begin
          if (done) begin
            r_cap <= {msb, lsb};
          end
        end
        ST_ACCUM: begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            r_sample <= 16'(w_sum >> AVG_LOG2);
          end
        end
        ST_OUTPUT: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign sample  = r_sample;
  assign overrun = r_overrun;

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;

  assign w_to_hit = (r_state == ST_REQ) && (r_wait == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == ST_REQ) && !done) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_to_hit && !done) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_poll.sv
// Directed bench for i2c_poll with a transaction-level averaging model.
`timescale 1ns/1ps
module tb_i2c_poll;

  localparam int unsigned PER = 100;
  localparam int unsigned AVG = 2;
  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  msb = 8'h00;
  logic [7:0]  lsb = 8'h00;
  logic        start, sample_vld, busy, overrun, timeout;
  logic [15:0] sample;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // model: averages every 2^AVG accepted reads, result visible 2 cycles after done
  int unsigned m_sum    = 0;
  int          m_n      = 0;
  int          pend_cyc = -1;
  logic [15:0] pend_val = 16'h0000;
  logic [15:0] m_sample = 16'h0000;

  i2c_poll #(
    .PERIOD_CYC (PER),
    .AVG_LOG2   (AVG),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .done      (done),
    .msb       (msb),
    .lsb       (lsb),
    .sample    (sample),
    .sample_vld(sample_vld),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_accept(input logic [15:0] v);
    m_sum += 32'(v);
    m_n++;
    if (m_n == (1 << AVG)) begin
      pend_cyc = cyc + 2;
      pend_val = 16'(m_sum >> AVG);
      m_sum    = 0;
      m_n      = 0;
    end
  endfunction

  function automatic void model_reset();
    m_sum    = 0;
    m_n      = 0;
    pend_cyc = -1;
    m_sample = 16'h0000;
  endfunction

  always @(negedge clk) begin
    bit exp_vld;
    if (mon_en) begin
      exp_vld = (cyc == pend_cyc);
      if (exp_vld) m_sample = pend_val;
      chk("sample_vld", 32'(sample_vld), 32'(exp_vld));
      chk("sample", 32'(sample), 32'(m_sample));
    end
  end

  task automatic wait_start(output int sc);
    int w;
    w = 0;
    @(negedge clk);
    while (start !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("start_arrives", 32'(start), 32'(1));
    sc = cyc;
  endtask

  task automatic serve(input logic [15:0] v, input int d, output int sc);
    wait_start(sc);
    repeat (d) @(posedge clk);
    @(posedge clk);
    #1;
    done = 1'b1;
    {msb, lsb} = v;
    model_accept(v);
    @(negedge clk);
    chk("start_held_at_done", 32'(start), 32'(1));
    @(posedge clk);
    #1;
    done = 1'b0;
    {msb, lsb} = 16'hC3C3;
    @(negedge clk);
    chk("start_drop_after_done", 32'(start), 32'(0));
    chk("busy_in_accum", 32'(busy), 32'(1));
  endtask

  task automatic expect_avg(input string name, input logic [15:0] val);
    @(negedge clk);
    chk({name, "_vld"}, 32'(sample_vld), 32'(1));
    chk(name, 32'(sample), 32'(val));
    @(negedge clk);
    chk({name, "_vld_one_cycle"}, 32'(sample_vld), 32'(0));
  endtask

  initial begin
    int c0, c1, n_hi, first;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;

    first = 0;
    for (int i = 1; i <= 110 && first == 0; i++) begin
      @(negedge clk);
      if (start === 1'b1) first = i;
    end
    chk("first_start_cycle", 32'(first), 32'(101));

    serve(16'h0102, 0, c0);
    serve(16'h0104, 0, c0);
    serve(16'h0106, 0, c0);
    serve(16'h0108, 0, c0);
    expect_avg("avg_0105", 16'h0105);

    serve(16'hFFFF, 0, c0);
    serve(16'hFFFF, 0, c0);
    serve(16'hFFFF, 0, c0);
    @(posedge clk);
    #1;
    done = 1'b1;
    {msb, lsb} = 16'h1234;
    @(negedge clk);
    chk("idle_done_ignored_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    done = 1'b0;
    serve(16'hFFFC, 0, c0);
    expect_avg("avg_fffe", 16'hFFFE);
    chk("no_overrun_yet", 32'(overrun), 32'(0));

    serve(16'h0010, 150, c0);
    serve(16'h0020, 0, c1);
    chk("one_tick_dropped_gap", 32'(c1 - c0), 32'(200));
    chk("overrun_set", 32'(overrun), 32'(1));
    serve(16'h0030, 0, c0);
    serve(16'h0040, 0, c0);
    expect_avg("avg_0028", 16'h0028);

    serve(16'h7777, 0, c0);
    serve(16'h8888, 0, c0);
    wait_start(c0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_midreq_start", 32'(start), 32'(0));
    chk("rst_midreq_busy", 32'(busy), 32'(0));
    chk("rst_midreq_overrun", 32'(overrun), 32'(0));
    serve(16'h1000, 0, c0);
    serve(16'h2000, 0, c0);
    serve(16'h3000, 0, c0);
    serve(16'h4000, 0, c0);
    expect_avg("avg_2800", 16'h2800);

    serve(16'h0001, 98, c0);
    serve(16'h0002, 0, c1);
    chk("tick_with_done_gap", 32'(c1 - c0), 32'(200));
    chk("tick_with_done_overrun", 32'(overrun), 32'(1));
    wait_start(c0);
    @(posedge clk);
    #1;
    en = 1'b0;
    serve(16'h0003, 2, c1);
    n_hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (start === 1'b1) n_hi++;
    end
    chk("en_low_no_request", 32'(n_hi), 32'(0));
    chk("en_low_idle", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    en = 1'b1;
    serve(16'h0004, 0, c0);
    expect_avg("avg_partial_kept", 16'h0002);

    wait_start(c0);
    n_hi = 1;
    repeat (59) begin
      @(negedge clk);
      if (start === 1'b1) n_hi++;
    end
`ifdef POLL_TIMEOUT_EN
    chk("timeout_start_cycles", 32'(n_hi), 32'(TMO));
    chk("timeout_flag", 32'(timeout), 32'(1));
    chk("timeout_idle", 32'(busy), 32'(0));
`else
    chk("no_timeout_start_cycles", 32'(n_hi), 32'(60));
    chk("no_timeout_flag", 32'(timeout), 32'(0));
    chk("no_timeout_busy", 32'(busy), 32'(1));
`endif
    serve(16'h0100, 0, c0);
    serve(16'h0200, 0, c0);
    serve(16'h0300, 0, c0);
    serve(16'h0400, 0, c0);
    expect_avg("avg_0280", 16'h0280);
`ifdef POLL_TIMEOUT_EN
    chk("timeout_sticky", 32'(timeout), 32'(1));
`else
    chk("timeout_tied_low", 32'(timeout), 32'(0));
`endif
    chk("overrun_sticky", 32'(overrun), 32'(1));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_poll.md
I2C_POLL -- requirements
Module: i2c_poll

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have these parameters:
  - PERIOD_CYC, default 1000000, clk cycles between poll ticks.
  - AVG_LOG2, default 2, log2 of the number of samples averaged.
  - TIMEOUT_CYC, default 65535, maximum cycles to wait for done.
REQ-003 The block SHALL have these ports:
  - clk  in  1  clock.
  - rst  in  1  synchronous reset, active high.
  - en  in  1  polling enable.
  - start  out  1  level request to the I2C transaction FSM.
  - done  in  1  transaction complete from the FSM; msb/lsb are valid while done=1.
  - msb  in  8  result high byte.
  - lsb  in  8  result low byte.
  - sample  out  16  averaged result.
  - sample_vld  out  1  one-cycle pulse, sample updated.
  - busy  out  1  high outside IDLE.
  - overrun  out  1  sticky, a tick was dropped.
  - timeout  out  1  sticky, a transaction timed out.

Function
REQ-004 The tick counter SHALL count 0..PERIOD_CYC-1 while en=1, emit a tick on wrap, and hold at 0 while en=0.
REQ-005 The FSM SHALL have states IDLE, REQ, ACCUM and OUTPUT.
REQ-006 IDLE SHALL go to REQ on a tick, with start=1 from the next cycle.
REQ-007 In REQ, start SHALL stay 1 until done=1 is sampled, then {msb,lsb} is captured in that cycle, start=0 next cycle, and the FSM goes to ACCUM.
REQ-008 ACCUM SHALL add the capture to a (16+AVG_LOG2)-bit accumulator (no overflow possible) and increment the sample count.
REQ-009 ACCUM SHALL go to OUTPUT when the count reaches 2^AVG_LOG2, else to IDLE.
REQ-010 OUTPUT SHALL load sample = accumulator >> AVG_LOG2 (truncating), pulse sample_vld for exactly one cycle, clear the accumulator and count, and return to IDLE.
REQ-011 Latency SHALL be: done at cycle t gives the accumulator update at t+1, and sample/sample_vld at t+2 for the final sample.
REQ-012 A tick arriving while not in IDLE SHALL be dropped and set overrun.
REQ-013 A tick and done in the same cycle SHALL process done and count as an overrun.
REQ-014 en falling mid-transaction SHALL let the current transaction complete and accumulate, SHALL start no new request, and SHALL retain the partial accumulation.
REQ-015 done asserted outside REQ SHALL be ignored.
REQ-016 overrun and timeout SHALL clear only on rst.

Reset
REQ-017 Reset SHALL force state IDLE, and start, sample, sample_vld, busy, overrun, timeout, the accumulator, the count and the tick counter all to 0.
REQ-018 Reset asserted mid-REQ SHALL drive start=0 in the cycle after reset is sampled and SHALL discard the partial accumulation.

Configuration
REQ-019 With POLL_TIMEOUT_EN defined:
  - a wait counter SHALL run in REQ;
  - on reaching TIMEOUT_CYC, start SHALL drop, timeout SHALL set, the sample is discarded and the FSM returns to IDLE.
REQ-020 Without POLL_TIMEOUT_EN, REQ SHALL wait indefinitely, timeout SHALL be tied 0, and no wait counter SHALL exist.

Structure
REQ-021 Package i2c_poll_pkg SHALL hold the state enum and the default PERIOD_CYC/AVG_LOG2/TIMEOUT_CYC constants.
REQ-022 The tick counter SHALL be sub-module poll_tick, with ports clk, rst, en and tick.

Verification (PERIOD_CYC=100, AVG_LOG2=2, TIMEOUT_CYC=50)
REQ-023 Reset, en=1 -> all outputs 0; first start=1 one cycle after the 100th counted cycle.
REQ-024 Reads 0x0102, 0x0104, 0x0106, 0x0108 -> sample=0x0105, sample_vld high one cycle, 2 cycles after the 4th done.
REQ-025 Reads 0xFFFF x3 then 0xFFFC -> sample=0xFFFE, no wrap.
REQ-026 done withheld 150 cycles -> overrun=1, exactly one tick dropped, the transaction still accumulates.
REQ-027 With POLL_TIMEOUT_EN and done never asserted -> start=0 after 50 REQ cycles, timeout=1, count unchanged. Without the macro, start stays 1 and timeout=0.
REQ-028 rst pulsed mid-REQ after 2 accumulated samples -> start=0 next cycle; the next 4 reads alone produce sample_vld.
